// File: rtl/cpu_pkg.sv
// Shared CPU definitions: reset vector, NOP encoding, fetch FSM states,
// fault causes and the IF/ID pipeline record.
package cpu_pkg;

  localparam int unsigned DATA_WIDTH   = 32;
  localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;
  localparam int unsigned IMEM_BYTES   = 4096;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT  = 2'b00,
    RUN   = 2'b01,
    HALT  = 2'b10,
    FAULT = 2'b11
  } fetch_state_t;

  typedef enum logic [1:0] {
    FC_NONE     = 2'b00,
    FC_MISALIGN = 2'b01,
    FC_RANGE    = 2'b10
  } fault_cause_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
  } if_id_t;

  // Unsigned offset from the base turns addresses below the base (or wrapped) into huge values.
  function automatic logic in_window(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [31:0] last_off);
    logic [31:0] offset;
    offset = addr - base;
    return (offset <= last_off);
  endfunction

  function automatic if_id_t if_id_bubble();
    if_id_t b;
    b.valid    = 1'b0;
    b.instr    = NOP_INSTR;
    b.pc       = 32'h0000_0000;
    b.pc_plus4 = 32'h0000_0000;
    return b;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: bubble has priority over load, otherwise holds.
// Resets asynchronously to a bubble.
module if_id_reg
  import cpu_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   i_load,
  input  logic   i_bubble,
  input  if_id_t i_d,
  output if_id_t o_q
);

  if_id_t r_q;

  // Pipeline record update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= if_id_bubble();
    end else if (i_bubble) begin
      r_q <= if_id_bubble();
    end else if (i_load) begin
      r_q <= i_d;
    end else begin
      r_q <= r_q;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, drives the ROM address and fills IF/ID.
// Handles stall, redirect, halt and sticky fetch faults.
module fetch_stage #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000,
  parameter int unsigned IMEM_BYTES   = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall_i,
  input  logic                  flush_i,
  input  logic [DATA_WIDTH-1:0] redirect_pc_i,
  input  logic                  halt_i,
  output logic [DATA_WIDTH-1:0] imem_addr_o,
  input  logic [DATA_WIDTH-1:0] imem_instr_i,
  output logic                  id_valid_o,
  output logic [DATA_WIDTH-1:0] id_instr_o,
  output logic [DATA_WIDTH-1:0] id_pc_o,
  output logic [DATA_WIDTH-1:0] id_pc_plus4_o,
  output logic                  halted_o,
  output logic                  fault_o,
  output logic [1:0]            fault_cause_o
);

  import cpu_pkg::*;

  localparam logic [31:0] LAST_OFF = 32'(IMEM_BYTES) - 32'd4;

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;
  fault_cause_t r_cause;
  fault_cause_t w_cause_nxt;
  logic [31:0]  r_pc;
  logic [31:0]  w_pc_nxt;
  logic [31:0]  w_pc_plus4;
  logic         w_load;
  logic         w_bubble;
  if_id_t       w_id_d;
  if_id_t       w_id_q;

  assign w_pc_plus4      = r_pc + 32'd4;
  assign w_id_d.valid    = 1'b1;
  assign w_id_d.instr    = imem_instr_i;
  assign w_id_d.pc       = r_pc;
  assign w_id_d.pc_plus4 = w_pc_plus4;

  // FSM state, program counter and fault cause registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= BOOT;
      r_pc    <= RESET_VECTOR;
      r_cause <= FC_NONE;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_cause <= w_cause_nxt;
    end
  end

  // Next-state, next-PC and IF/ID control in RUN priority order: flush, halt, stall, fetch.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_cause_nxt = r_cause;
    w_load      = 1'b0;
    w_bubble    = 1'b0;
    case (r_state)
      BOOT: begin
        w_bubble    = 1'b1;
        w_state_nxt = RUN;
      end
      RUN: begin
        if (flush_i) begin
          w_bubble = 1'b1;
          if (redirect_pc_i[1:0] != 2'b00) begin
            w_state_nxt = FAULT;
            w_cause_nxt = FC_MISALIGN;
          end else if (!in_window(redirect_pc_i, RESET_VECTOR, LAST_OFF)) begin
            w_state_nxt = FAULT;
            w_cause_nxt = FC_RANGE;
          end else begin
            w_pc_nxt = redirect_pc_i;
          end
        end else if (halt_i) begin
          w_bubble    = 1'b1;
          w_state_nxt = HALT;
        end else if (stall_i) begin
          w_load = 1'b0;
        end else begin
          // The last in-window word is still delivered; only the PC step faults.
          w_load = 1'b1;
          if (!in_window(w_pc_plus4, RESET_VECTOR, LAST_OFF)) begin
            w_state_nxt = FAULT;
            w_cause_nxt = FC_RANGE;
          end else begin
            w_pc_nxt = w_pc_plus4;
          end
        end
      end
      HALT: begin
        w_bubble = 1'b1;
      end
      FAULT: begin
        w_bubble = 1'b1;
      end
      default: begin
        w_bubble    = 1'b1;
        w_state_nxt = FAULT;
      end
    endcase
  end

  if_id_reg u_if_id_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_load),
    .i_bubble (w_bubble),
    .i_d      (w_id_d),
    .o_q      (w_id_q)
  );

  assign imem_addr_o   = r_pc;
  assign id_valid_o    = w_id_q.valid;
  assign id_instr_o    = w_id_q.instr;
  assign id_pc_o       = w_id_q.pc;
  assign id_pc_plus4_o = w_id_q.pc_plus4;
  assign halted_o      = (r_state == HALT);
  assign fault_o       = (r_state == FAULT);
  assign fault_cause_o = r_cause;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, corner sequences,
// and randomized traffic against a behavioural fetch model.
module tb_fetch_stage;

  localparam logic [31:0] RV   = 32'hBFC0_0000;
  localparam logic [31:0] LAST = 32'hBFC0_0FFC;
  localparam int M_BOOT = 0, M_RUN = 1, M_HALT = 2, M_FAULT = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_i = 1'b0, flush_i = 1'b0, halt_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'h0;
  logic [31:0] imem_addr_o, imem_instr_i, id_instr_o, id_pc_o, id_pc_plus4_o;
  logic        id_valid_o, halted_o, fault_o;
  logic [1:0]  fault_cause_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] rom [0:1023];
  logic [31:0] rom_off;
  assign rom_off      = imem_addr_o - RV;
  assign imem_instr_i = rom[rom_off[11:2]];

  always #5 clk = ~clk;

  fetch_stage #(.DATA_WIDTH(32), .RESET_VECTOR(RV), .IMEM_BYTES(4096)) dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i),
    .redirect_pc_i(redirect_pc_i), .halt_i(halt_i), .imem_addr_o(imem_addr_o),
    .imem_instr_i(imem_instr_i), .id_valid_o(id_valid_o), .id_instr_o(id_instr_o),
    .id_pc_o(id_pc_o), .id_pc_plus4_o(id_pc_plus4_o), .halted_o(halted_o),
    .fault_o(fault_o), .fault_cause_o(fault_cause_o)
  );

  // Behavioural model: fetch mode, PC, fault cause, and what IF/ID should hold.
  int          m_mode;
  logic [31:0] m_pc;
  logic [1:0]  m_cause;
  logic        m_v;
  logic [31:0] m_ipc;

  function automatic logic legal(input logic [31:0] a);
    return (a >= RV) && (a <= LAST);
  endfunction

  function automatic logic [31:0] rom_at(input logic [31:0] a);
    logic [31:0] off;
    off = a - RV;
    return rom[off[11:2]];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] e_addr, input logic e_v,
                         input logic [31:0] e_pc, input logic e_halt, input logic e_fault,
                         input logic [1:0] e_cause);
    chk({tag, ".addr"},  imem_addr_o, e_addr);
    chk({tag, ".valid"}, {31'b0, id_valid_o}, {31'b0, e_v});
    chk({tag, ".instr"}, id_instr_o, e_v ? rom_at(e_pc) : 32'h0000_0013);
    chk({tag, ".pc"},    id_pc_o, e_v ? e_pc : 32'h0);
    chk({tag, ".pc4"},   id_pc_plus4_o, e_v ? e_pc + 32'd4 : 32'h0);
    chk({tag, ".halt"},  {31'b0, halted_o}, {31'b0, e_halt});
    chk({tag, ".fault"}, {31'b0, fault_o}, {31'b0, e_fault});
    chk({tag, ".cause"}, {30'b0, fault_cause_o}, {30'b0, e_cause});
  endtask

  task automatic chk_model(input string tag);
    chk_all(tag, m_pc, m_v, m_ipc, m_mode == M_HALT, m_mode == M_FAULT, m_cause);
  endtask

  task automatic model_step(input logic s, input logic f, input logic h, input logic [31:0] r);
    logic [31:0] nxt;
    case (m_mode)
      M_BOOT: begin m_v = 1'b0; m_ipc = 32'h0; m_mode = M_RUN; end
      M_RUN: begin
        if (f) begin
          m_v = 1'b0; m_ipc = 32'h0;
          if (r % 4 != 0) begin m_mode = M_FAULT; m_cause = 2'd1; end
          else if (!legal(r)) begin m_mode = M_FAULT; m_cause = 2'd2; end
          else m_pc = r;
        end else if (h) begin
          m_v = 1'b0; m_ipc = 32'h0; m_mode = M_HALT;
        end else if (!s) begin
          m_v = 1'b1; m_ipc = m_pc;
          nxt = m_pc + 32'd4;
          if (!legal(nxt)) begin m_mode = M_FAULT; m_cause = 2'd2; end
          else m_pc = nxt;
        end
      end
      default: begin m_v = 1'b0; m_ipc = 32'h0; end
    endcase
  endtask

  task automatic drive(input logic s, input logic f, input logic h, input logic [31:0] r);
    stall_i = s; flush_i = f; halt_i = h; redirect_pc_i = r;
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic s, input logic f, input logic h, input logic [31:0] r,
                     input string tag);
    model_step(s, f, h, r);
    drive(s, f, h, r);
    chk_model(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    stall_i = 1'b0; flush_i = 1'b0; halt_i = 1'b0; redirect_pc_i = 32'h0;
    @(posedge clk);
    #1;
    m_mode = M_BOOT; m_pc = RV; m_cause = 2'd0; m_v = 1'b0; m_ipc = 32'h0;
    chk_model("rst");
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rand_target();
    logic [31:0] t;
    t = $urandom_range(0, 1023);
    case ($urandom_range(0, 7))
      0, 1, 2, 3: return RV + (t << 2);
      4:          return ($urandom_range(0, 1) == 0) ? LAST : LAST - 32'd4;
      5:          return RV + (t << 2) + 32'($urandom_range(1, 3));
      6:          return ($urandom_range(0, 1) == 0) ? RV - 32'd4 : RV + 32'd4096;
      default:    return ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
    endcase
  endfunction

  typedef struct {
    logic        s, f, h;
    logic [31:0] r;
    logic [31:0] e_addr;
    logic        e_v;
    logic [31:0] e_pc;
    logic        e_halt, e_fault;
    logic [1:0]  e_cause;
  } vec_t;

  vec_t tbl [10];

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = $urandom();
    rom[0] = 32'h0050_0093;

    tbl[0] = '{1'b1, 1'b1, 1'b1, 32'hBFC0_0200, 32'hBFC0_0000, 1'b0, 32'h0,         1'b0, 1'b0, 2'd0};
    tbl[1] = '{1'b0, 1'b0, 1'b0, 32'h0,         32'hBFC0_0004, 1'b1, 32'hBFC0_0000, 1'b0, 1'b0, 2'd0};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 32'h0,         32'hBFC0_0004, 1'b1, 32'hBFC0_0000, 1'b0, 1'b0, 2'd0};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 32'h0,         32'hBFC0_0004, 1'b1, 32'hBFC0_0000, 1'b0, 1'b0, 2'd0};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 32'h0,         32'hBFC0_0004, 1'b1, 32'hBFC0_0000, 1'b0, 1'b0, 2'd0};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 32'h0,         32'hBFC0_0008, 1'b1, 32'hBFC0_0004, 1'b0, 1'b0, 2'd0};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 32'hBFC0_0100, 32'hBFC0_0100, 1'b0, 32'h0,         1'b0, 1'b0, 2'd0};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 32'h0,         32'hBFC0_0104, 1'b1, 32'hBFC0_0100, 1'b0, 1'b0, 2'd0};
    tbl[8] = '{1'b1, 1'b0, 1'b1, 32'h0,         32'hBFC0_0104, 1'b0, 32'h0,         1'b1, 1'b0, 2'd0};
    tbl[9] = '{1'b0, 1'b1, 1'b0, 32'hBFC0_0200, 32'hBFC0_0104, 1'b0, 32'h0,         1'b1, 1'b0, 2'd0};

    // Directed table: boot, stall, flush-over-stall, halt.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].s, tbl[i].f, tbl[i].h, tbl[i].r);
      chk_all($sformatf("tbl%0d", i), tbl[i].e_addr, tbl[i].e_v, tbl[i].e_pc,
              tbl[i].e_halt, tbl[i].e_fault, tbl[i].e_cause);
      if (i == 1) chk("tbl1.rominstr", id_instr_o, 32'h0050_0093);
    end

    // Misaligned redirect beats halt/stall; fault is sticky; async reset clears it.
    do_reset();
    cyc(1'b0, 1'b0, 1'b0, 32'h0, "misA.boot");
    cyc(1'b0, 1'b0, 1'b0, 32'h0, "misA.f0");
    cyc(1'b1, 1'b1, 1'b1, 32'hBFC0_0102, "misA.flush");
    chk_all("misA.hand", 32'hBFC0_0004, 1'b0, 32'h0, 1'b0, 1'b1, 2'd1);
    for (int i = 0; i < 4; i++)
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          RV + 32'h40, "misA.stuck");
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("misA.arst", RV, 1'b0, 32'h0, 1'b0, 1'b0, 2'd0);

    // Aligned redirect outside the window, below and above.
    do_reset();
    cyc(1'b0, 1'b0, 1'b0, 32'h0, "rngB.boot");
    cyc(1'b0, 1'b1, 1'b0, 32'hBFC0_1000, "rngB.flush");
    chk_all("rngB.hand", RV, 1'b0, 32'h0, 1'b0, 1'b1, 2'd2);
    do_reset();
    cyc(1'b0, 1'b0, 1'b0, 32'h0, "rngC.boot");
    cyc(1'b0, 1'b1, 1'b0, 32'hBFBF_FFFC, "rngC.flush");

    // Sequential run off the end of the window.
    do_reset();
    cyc(1'b0, 1'b0, 1'b0, 32'h0, "seq.boot");
    for (int k = 0; k < 1024; k++) cyc(1'b0, 1'b0, 1'b0, 32'h0, "seq");
    chk_all("seq.last", LAST, 1'b1, LAST, 1'b0, 1'b1, 2'd2);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, "seq.after");
    chk_all("seq.after.hand", LAST, 1'b0, 32'h0, 1'b0, 1'b1, 2'd2);

    // Halt then asynchronous reset in the middle of a cycle.
    do_reset();
    cyc(1'b0, 1'b0, 1'b0, 32'h0, "hlt.boot");
    cyc(1'b0, 1'b0, 1'b0, 32'h0, "hlt.f0");
    cyc(1'b1, 1'b0, 1'b1, 32'h0, "hlt.halt");
    chk_all("hlt.hand", 32'hBFC0_0004, 1'b0, 32'h0, 1'b1, 1'b0, 2'd0);
    cyc(1'b0, 1'b1, 1'b0, RV + 32'h10, "hlt.ignored");
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("hlt.arst", RV, 1'b0, 32'h0, 1'b0, 1'b0, 2'd0);

    // Randomized traffic against the model.
    for (int ep = 0; ep < 8; ep++) begin
      do_reset();
      for (int c = 0; c < 300; c++) begin
        cyc(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 9) == 0),
            1'($urandom_range(0, 79) == 0), rand_target(), $sformatf("rnd%0d", ep));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the asynchronous instruction ROM.
- Owns the program counter and drives the ROM address. Captures the returned instruction into the IF/ID pipeline register for decode.
- Handles hazard stalls, branch/jump redirects, halt requests, and fetch faults (misaligned target, address outside the ROM window).

Parameters:
- DATA_WIDTH, 32, instruction and PC width.
- RESET_VECTOR, 32'hBFC0_0000, first fetch address and base of the ROM window.
- IMEM_BYTES, 4096, ROM window size in bytes; legal PC range is RESET_VECTOR to RESET_VECTOR+IMEM_BYTES-4.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- stall_i  in  1  hazard unit; hold PC and IF/ID
- flush_i  in  1  EX-stage redirect request
- redirect_pc_i  in  32  redirect target, valid while flush_i=1
- halt_i  in  1  stop fetching, e.g. on ebreak retire
- imem_addr_o  out  32  PC to the instruction ROM; equals the pc register (combinational)
- imem_instr_i  in  32  ROM read data, valid in the same cycle
- id_valid_o  out  1  IF/ID holds a real instruction
- id_instr_o  out  32  IF/ID instruction
- id_pc_o  out  32  IF/ID PC
- id_pc_plus4_o  out  32  IF/ID PC+4, used for JAL/JALR link
- halted_o  out  1  state is HALT
- fault_o  out  1  state is FAULT (sticky until reset)
- fault_cause_o  out  2  00 none, 01 misaligned, 10 out-of-range

Behaviour:
- Reset is asynchronous active-low, one clock domain.
- Values while rst_n=0:
  - pc = RESET_VECTOR
  - id_valid_o = 0
  - id_instr_o = 32'h0000_0013 (NOP)
  - id_pc_o = 0, id_pc_plus4_o = 0
  - fault_cause_o = 00
  - state = BOOT
- FSM states: BOOT, RUN, HALT, FAULT.
- BOOT:
  - Lasts exactly one cycle after reset release.
  - IF/ID gets a bubble; pc is held; next state is RUN.
  - stall_i, flush_i and halt_i are ignored.
- RUN, evaluated each rising edge in priority order:
  1. flush_i=1:
     - If redirect_pc_i[1:0]!=0: go to FAULT, cause 01, pc is held.
     - Else if the target is outside the window: go to FAULT, cause 10.
     - Otherwise pc <= redirect_pc_i.
     - In every case IF/ID gets a bubble.
     - flush overrides stall and halt in the same cycle.
  2. halt_i=1: go to HALT, IF/ID gets a bubble, pc is held.
  3. stall_i=1: pc and IF/ID hold all their values.
  4. Otherwise:
     - IF/ID <= {1, imem_instr_i, pc, pc+4}.
     - If pc+4 is outside the window: go to FAULT, cause 10, pc is held. The last in-window instruction is still captured as valid.
     - Else pc <= pc+4.
- HALT and FAULT are terminal until reset. IF/ID holds a bubble and all inputs are ignored.
- Fetch latency: an instruction at PC appears on id_* one edge after imem_addr_o=PC, unless stalled.
- Arithmetic is 32-bit modulo 2^32. A wrap past 32'hFFFF_FFFC is caught by the window check.
- Bubble means valid=0, instr=NOP, pc=0, pc_plus4=0.
- A reset assertion mid-stall or mid-flush takes effect immediately (asynchronous), with no partial update.

Decomposition:
- The shared package cpu_pkg holds:
  - RESET_VECTOR and the NOP_INSTR constant.
  - The typedef enum fetch_state_t {BOOT, RUN, HALT, FAULT}.
  - The typedef enum fault_cause_t {FC_NONE, FC_MISALIGN, FC_RANGE}.
  - The typedef struct if_id_t {valid, instr, pc, pc_plus4}.
- One sub-module, if_id_reg:
  - IF/ID register with load, bubble and hold controls.
  - Asynchronous active-low reset to a bubble.
- The FSM and next-PC logic stay in fetch_stage.

Test Plan:
- Reset release, ROM returns 32'h00500093 at 0xBFC00000: cycle 1 id_valid_o=0 (BOOT); next edge id_instr_o=32'h00500093, id_pc_o=0xBFC00000, id_pc_plus4_o=0xBFC00004, imem_addr_o=0xBFC00004.
- stall_i=1 for 3 cycles in RUN: imem_addr_o and all id_* are constant; after release, fetch resumes at the same PC with no instruction lost or duplicated.
- flush_i=1 with stall_i=1 and redirect_pc_i=0xBFC00100: next edge imem_addr_o=0xBFC00100 and id_valid_o=0; the following edge captures PC 0xBFC00100.
- flush_i=1 with redirect_pc_i=0xBFC00102: fault_o=1, fault_cause_o=01, id_valid_o=0; then toggling any input changes nothing; rst_n low clears the fault and pc=0xBFC00000.
- Sequential run to pc=0xBFC00FFC: instruction at 0xBFC00FFC is captured with valid=1; next cycle fault_cause_o=10, imem_addr_o stays 0xBFC00FFC.
- halt_i=1 in RUN: halted_o=1 next edge, id_valid_o=0, pc frozen; asynchronous rst_n assertion mid-cycle forces all outputs to reset values immediately.
